hex_digit_counter: RTL and testbench

- Upstream stage for the hex_decoder / seven-segment path. Produces the 4-bit value driven onto the decoder's c3..c0 inputs.
- Contains a rate divider and a 4-bit up/down counter with parallel load. Advances the digit at a selectable rate: every clock, 1 Hz, 0.5 Hz or 0.25 Hz.
- On the board, `digit[3:0]` connects directly to the decoder inputs `c0`..`c3`, LSB to `c0`.

---
 rtl/hex_digit_counter.sv | 97 +++++++++
 tb/tb_hex_digit_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hex_digit_counter.sv
// Hex digit source for the seven-segment decoder path: a reloadable rate divider
// gating a 4-bit up/down counter with parallel load and wrap/advance pulses.
module hex_digit_counter #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned DIV_W         = 28
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       tick,
    output logic       carry
);

    localparam logic [DIV_W-1:0] RELOAD_1S = DIV_W'(TICKS_PER_SEC - 1);
    localparam logic [DIV_W-1:0] RELOAD_2S = DIV_W'(2 * TICKS_PER_SEC - 1);
    localparam logic [DIV_W-1:0] RELOAD_4S = DIV_W'(4 * TICKS_PER_SEC - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       rate_q, rate_d;
    logic [3:0]       digit_q, digit_d;
    logic             tick_q, tick_d;
    logic             carry_q, carry_d;

    logic [DIV_W-1:0] reload_c;
    logic             rate_change_c;
    logic             div_zero_c;
    logic             adv_c;

    // Divider reload for the currently requested rate
    always_comb begin
        reload_c = '0;
        case (rate_sel)
            2'b01:   reload_c = RELOAD_1S;
            2'b10:   reload_c = RELOAD_2S;
            2'b11:   reload_c = RELOAD_4S;
            default: reload_c = '0;
        endcase
    end

    assign rate_change_c = (rate_sel != rate_q);
    assign div_zero_c    = (div_cnt_q == '0);
    assign adv_c         = enable & div_zero_c & ~load & ~rate_change_c;

    always_comb begin
        div_cnt_d = div_cnt_q;
        rate_d    = rate_q;
        digit_d   = digit_q;
        tick_d    = 1'b0;
        carry_d   = 1'b0;

        // A rate switch restarts the period and suppresses any advance on this edge
        if (rate_change_c) begin
            div_cnt_d = reload_c;
            rate_d    = rate_sel;
        end else if (load) begin
            div_cnt_d = reload_c;
        end else if (enable && div_zero_c) begin
            div_cnt_d = reload_c;
        end else if (enable) begin
            div_cnt_d = div_cnt_q - DIV_W'(1);
        end

        if (load) begin
            digit_d = load_value;
        end else if (adv_c) begin
            digit_d = up ? (digit_q + 4'd1) : (digit_q - 4'd1);
            tick_d  = 1'b1;
            carry_d = up ? (digit_q == 4'hF) : (digit_q == 4'h0);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            rate_q    <= 2'b00;
            digit_q   <= 4'h0;
            tick_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            rate_q    <= rate_d;
            digit_q   <= digit_d;
            tick_q    <= tick_d;
            carry_q   <= carry_d;
        end
    end

    assign digit = digit_q;
    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Scoreboard bench for hex_digit_counter: directed scenarios followed by random
// stimulus, checked against a period/countdown reference model.
module tb_hex_digit_counter;

    localparam int unsigned TPS = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] rate_sel = 2'b00;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'h0;
    logic [3:0] digit;
    logic       tick;
    logic       carry;

    hex_digit_counter #(.TICKS_PER_SEC(TPS), .DIV_W(28)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .rate_sel(rate_sel),
        .up(up), .load(load), .load_value(load_value),
        .digit(digit), .tick(tick), .carry(carry)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] digit;
        logic       tick;
        logic       carry;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: clocks left in the current period, active rate, digit value
    int m_left  = 0;
    int m_rate  = 0;
    int m_digit = 0;
    bit m_tick  = 0;
    bit m_carry = 0;

    function automatic int period_len(input int rs);
        if (rs == 0) return 0;
        return (TPS << (rs - 1)) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_edge(input bit en, input int rs, input bit u, input bit ld, input int lv);
        bit adv;
        adv = en && (m_left == 0) && !ld && (rs == m_rate);
        if (rs != m_rate) begin
            m_left = period_len(rs);
            m_rate = rs;
        end else if (ld || (en && m_left == 0)) begin
            m_left = period_len(rs);
        end else if (en) begin
            m_left = m_left - 1;
        end
        m_tick  = 0;
        m_carry = 0;
        if (ld) begin
            m_digit = lv;
        end else if (adv) begin
            m_carry = u ? (m_digit == 15) : (m_digit == 0);
            m_digit = u ? (m_digit + 1) % 16 : (m_digit + 15) % 16;
            m_tick  = 1;
        end
    endtask

    task automatic step(input bit rn, input bit en, input logic [1:0] rs, input bit u,
                        input bit ld, input logic [3:0] lv);
        exp_t e;
        @(negedge clock);
        resetn = rn; enable = en; rate_sel = rs; up = u; load = ld; load_value = lv;
        if (!rn) begin
            m_left = 0; m_rate = 0; m_digit = 0; m_tick = 0; m_carry = 0;
        end else begin
            model_edge(en, int'(rs), u, ld, int'(lv));
        end
        e.digit = 4'(m_digit);
        e.tick  = m_tick;
        e.carry = m_carry;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, compare shortly after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("digit", int'(digit), int'(e.digit));
                chk("tick",  int'(tick),  int'(e.tick));
                chk("carry", int'(carry), int'(e.carry));
            end
        end
    end

    initial begin
        #12;
        chk("reset_digit", int'(digit), 0);
        chk("reset_tick",  int'(tick),  0);
        chk("reset_carry", int'(carry), 0);

        // Every-clock counting up through the wrap
        step(0, 1, 2'b00, 1, 0, 4'h0);
        repeat (20) step(1, 1, 2'b00, 1, 0, 4'h0);

        // Slow rates held from reset
        for (int r = 1; r < 4; r++) begin
            step(0, 1, 2'(r), 1, 0, 4'h0);
            repeat (40) step(1, 1, 2'(r), 1, 0, 4'h0);
        end

        // Load then count down across 0 -> F
        step(1, 1, 2'b01, 0, 1, 4'h1);
        repeat (12) step(1, 1, 2'b01, 0, 0, 4'h0);

        // Enable pause two clocks after an advance
        for (int i = 0; i < 10 && !m_tick; i++) step(1, 1, 2'b01, 1, 0, 4'h0);
        repeat (2) step(1, 1, 2'b01, 1, 0, 4'h0);
        repeat (10) step(1, 0, 2'b01, 1, 0, 4'h0);
        repeat (8) step(1, 1, 2'b01, 1, 0, 4'h0);

        // Load colliding with a due advance
        for (int i = 0; i < 10 && m_left != 0; i++) step(1, 1, 2'b01, 1, 0, 4'h0);
        step(1, 1, 2'b01, 1, 1, 4'hA);
        repeat (6) step(1, 1, 2'b01, 1, 0, 4'h0);

        // Asynchronous reset between edges while showing 7
        step(1, 0, 2'b01, 1, 1, 4'h7);
        @(posedge clock);
        #2;
        chk("pre_reset_digit", int'(digit), 7);
        resetn = 1'b0;
        #1;
        chk("async_digit", int'(digit), 0);
        chk("async_tick",  int'(tick),  0);
        chk("async_carry", int'(carry), 0);
        repeat (3) step(0, 1, 2'b01, 1, 0, 4'h0);
        repeat (6) step(1, 1, 2'b00, 1, 0, 4'h0);

        // Random traffic
        begin
            logic [1:0] rs;
            rs = 2'b00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(39) == 0) rs = 2'($urandom_range(3));
                step($urandom_range(299) != 0, $urandom_range(9) < 8, rs,
                     1'($urandom_range(1)), $urandom_range(19) == 0, 4'($urandom_range(15)));
            end
        end

        repeat (3) @(posedge clock);
        #2;
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
